npc_fetch_sequencer: RTL and testbench
======================================

// Module: npc_fetch_sequencer
// PURPOSE
//  Multi-cycle instruction sequencer for the NPC core. Owns the PC register,
//  issues instruction fetches over a valid/ready request/response pair, holds
//  the fetched instruction for the EXU, and on EXU completion selects the next
//  PC from the branch/jump decision (pc+4 or branch target). Sits between IMEM
//  and the IDU/EXU, replacing the single-cycle PC update path.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC value loaded on reset
//  XLEN       32             address/instruction width
// PORTS
//  clk             in   1     core clock
//  rst_n           in   1     asynchronous active-low reset
//  ifu_req_valid   out  1     fetch request valid
//  ifu_req_ready   in   1     IMEM accepts request
//  ifu_req_addr    out  XLEN  fetch address (= pc)
//  ifu_rsp_valid   in   1     IMEM returns instruction
//  ifu_rsp_ready   out  1     sequencer accepts response
//  ifu_rsp_inst    in   XLEN  returned instruction word
//  inst            out  XLEN  latched instruction for IDU/EXU
//  pc              out  XLEN  PC of instruction in flight
//  exu_start       out  1     one-cycle pulse: inst/pc valid, begin execute
//  exu_done        in   1     EXU finished; branch_taken/target/halt valid
//  branch_taken    in   1     branch/jump resolved taken (pcAdderBSel)
//  branch_target   in   XLEN  next PC when taken
//  halt            in   1     ebreak; sampled with exu_done
//  halted          out  1     sequencer stopped
//  retire_cnt      out  32    retired-instruction counter
//  misalign_trap   out  1     see CONFIGURATION (0 when macro absent)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, inst=0, retire_cnt=0,
//   halted=0, all valid/ready/start/trap outputs 0.
//  States: IDLE, FETCH, WAIT_RSP, EXEC, HALT.
//  - IDLE: -> FETCH next cycle unconditionally.
//  - FETCH: ifu_req_valid=1, ifu_req_addr=pc held stable until handshake;
//    req_valid&req_ready -> WAIT_RSP.
//  - WAIT_RSP: ifu_rsp_ready=1; rsp_valid -> latch inst<=ifu_rsp_inst, -> EXEC.
//    ifu_rsp_valid outside WAIT_RSP is ignored (rsp_ready=0).
//  - EXEC: exu_start=1 only on first EXEC cycle. exu_done sampled every EXEC
//    cycle incl. the first. On exu_done:
//      halt=1 -> HALT, pc unchanged, retire_cnt+1;
//      else pc <= branch_taken ? branch_target : pc+4 (mod 2^XLEN),
//      retire_cnt+1 (wraps at 2^32), -> FETCH.
//    halt without exu_done ignored.
//  - HALT: halted=1, all handshake outputs 0; exit only by reset.
//  inst and pc stable from exu_start until exu_done.
//  Min latency: 3 cycles/instruction (ready, rsp_valid, exu_done each on
//   first eligible cycle). Stalls on any input extend the state indefinitely.
//  Reset mid-transaction aborts immediately; outstanding IMEM response is
//   the memory's responsibility to drop.
// CONFIGURATION
//  NPC_MISALIGN_TRAP_EN defined: taken branch with branch_target[1:0]!=0 at
//   exu_done -> pc unchanged, misalign_trap=1 (registered, held), -> HALT,
//   retire_cnt not incremented.
//  Not defined: target low 2 bits forced to 0; misalign_trap tied 0.
// TESTING
//  1. Reset release, ready/rsp_valid/exu_done tied 1 -> req_addr 0x80000000,
//     0x80000004, 0x80000008 on consecutive 3-cycle periods; retire_cnt=1,2,3.
//  2. ifu_req_ready low 5 cycles -> req_valid held, addr stable, no state move.
//  3. branch_taken=1, target=0x80000100 at exu_done -> next req_addr
//     0x80000100; taken=0 -> pc+4.
//  4. halt=1 with exu_done -> halted=1, no further req_valid, pc unchanged;
//     halt=1 without exu_done -> ignored.
//  5. target=0x80000102 taken: with macro -> misalign_trap=1, halted=1,
//     retire_cnt unchanged; without -> next addr 0x80000100.
//  6. rst_n low during WAIT_RSP -> outputs at reset values same cycle; refetch
//     from 0x80000000 after release.

Source files
------------

// File: rtl/npc_fetch_sequencer.sv
// npc_fetch_sequencer
// Multi-cycle instruction sequencer for the NPC core. It owns the PC, issues
// fetches over a valid/ready request/response pair, and holds the fetched
// instruction for the EXU. When the EXU completes, it picks the next PC
// (pc+4 or the resolved branch target).
//
// Optional feature macro: NPC_MISALIGN_TRAP_EN
//   defined   : a taken branch to a non word-aligned target traps into HALT
//               with misalign_trap raised, and does not retire.
//   undefined : the low two target bits are cleared and misalign_trap is 0.
module npc_fetch_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_rsp_valid,
  output logic            ifu_rsp_ready,
  input  logic [XLEN-1:0] ifu_rsp_inst,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic            exu_start,
  input  logic            exu_done,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            halt,
  output logic            halted,
  output logic [31:0]     retire_cnt,
  output logic            misalign_trap
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_RSP = 3'd2,
    S_EXEC     = 3'd3,
    S_HALT     = 3'd4
  } state_t;

  state_t state, next_state;

  // High only during the first EXEC cycle, so exu_start is a single pulse.
  logic exec_first;

  logic trap_hit;
  logic commit_next_pc;
  logic retire_now;

  // Sequential PC increment; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_increment(input logic [XLEN-1:0] cur);
    return cur + XLEN'(4);
  endfunction

  // Clears the byte-offset bits so the fetch address stays word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

  // Selects the next PC from the branch decision.
  function automatic logic [XLEN-1:0] next_pc_sel(input logic            taken,
                                                  input logic [XLEN-1:0] target,
                                                  input logic [XLEN-1:0] cur);
    return taken ? word_align(target) : pc_increment(cur);
  endfunction

`ifdef NPC_MISALIGN_TRAP_EN
  assign trap_hit = branch_taken && (branch_target[1:0] != 2'b00);
`else
  assign trap_hit = 1'b0;
`endif

  // A halt takes priority over a misaligned branch. The ebreak still retires.
  assign retire_now     = (state == S_EXEC) && exu_done && (halt || !trap_hit);
  assign commit_next_pc = (state == S_EXEC) && exu_done && !halt && !trap_hit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        next_state = S_FETCH;
      end
      S_FETCH: begin
        if (ifu_req_ready) begin
          next_state = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (ifu_rsp_valid) begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exu_done) begin
          if (halt || trap_hit) begin
            next_state = S_HALT;
          end else begin
            next_state = S_FETCH;
          end
        end
      end
      S_HALT: begin
        next_state = S_HALT;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state
  always_comb begin
    ifu_req_valid = 1'b0;
    ifu_rsp_ready = 1'b0;
    exu_start     = 1'b0;
    halted        = 1'b0;
    case (state)
      S_FETCH:    ifu_req_valid = 1'b1;
      S_WAIT_RSP: ifu_rsp_ready = 1'b1;
      S_EXEC:     exu_start     = exec_first;
      S_HALT:     halted        = 1'b1;
      default:    ;
    endcase
  end

  // The fetch address is the architectural PC. It is stable until exu_done.
  assign ifu_req_addr = pc;

  // Datapath registers: PC, latched instruction and the first-EXEC marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      inst       <= '0;
      exec_first <= 1'b0;
    end else begin
      exec_first <= (state == S_WAIT_RSP) && ifu_rsp_valid;
      if ((state == S_WAIT_RSP) && ifu_rsp_valid) begin
        inst <= ifu_rsp_inst;
      end
      if (commit_next_pc) begin
        pc <= next_pc_sel(branch_taken, branch_target, pc);
      end
    end
  end

  // Retired-instruction counter; wraps at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (retire_now) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

`ifdef NPC_MISALIGN_TRAP_EN
  // Sticky trap flag: set on a misaligned taken branch, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_trap <= 1'b0;
    end else if ((state == S_EXEC) && exu_done && !halt && trap_hit) begin
      misalign_trap <= 1'b1;
    end
  end
`else
  assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_npc_fetch_sequencer.sv
// Testbench for npc_fetch_sequencer. The bench acts as IMEM and EXU. Expected
// fetch addresses and instruction words go into queues as stimulus is driven.
// They are popped and compared when the sequencer presents a fetch or an
// exu_start.
module tb_npc_fetch_sequencer;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [XLEN-1:0] ifu_req_addr;
  logic            ifu_rsp_valid;
  logic            ifu_rsp_ready;
  logic [XLEN-1:0] ifu_rsp_inst;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] pc;
  logic            exu_start;
  logic            exu_done;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            halt;
  logic            halted;
  logic [31:0]     retire_cnt;
  logic            misalign_trap;

  npc_fetch_sequencer #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_inst  (ifu_rsp_inst),
    .inst          (inst),
    .pc            (pc),
    .exu_start     (exu_start),
    .exu_done      (exu_done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .halted        (halted),
    .retire_cnt    (retire_cnt),
    .misalign_trap (misalign_trap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_hs;
  bit last_ok;

  logic [31:0] addr_q[$];
  logic [31:0] inst_q[$];
  logic [31:0] exp_retire;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    exu_done      = 1'b0;
    branch_taken  = 1'b0;
    halt          = 1'b0;
    #1;
    check("rst_pc", pc, RESET_PC);
    check("rst_addr", ifu_req_addr, RESET_PC);
    check("rst_inst", inst, 32'h0);
    check("rst_retire", retire_cnt, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_req_valid", {31'b0, ifu_req_valid}, 32'h0);
    check("rst_rsp_ready", {31'b0, ifu_rsp_ready}, 32'h0);
    check("rst_exu_start", {31'b0, exu_start}, 32'h0);
    check("rst_trap", {31'b0, misalign_trap}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    addr_q.delete();
    inst_q.delete();
    addr_q.push_back(RESET_PC);
    exp_retire = 32'h0;
    last_ok    = 1'b0;
  endtask

  // Waits (bounded) for a fetch request and compares it with the scoreboard.
  task automatic wait_fetch(output logic [31:0] a);
    int n = 0;
    while (ifu_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_valid", {31'b0, ifu_req_valid}, 32'h1);
    a = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hxxxx_xxxx;
    check("req_addr", ifu_req_addr, a);
    check("pc_at_fetch", pc, a);
  endtask

  // Runs one full instruction. Starts and ends on a falling edge.
  task automatic run_instr(input logic [31:0] word, input bit taken,
                           input logic [31:0] tgt, input bit hlt,
                           input int req_st, input int rsp_st, input int exu_st);
    logic [31:0] a, w, nxt;
    bit trap;
    trap = 1'b0;
    wait_fetch(a);
    if (last_ok) check("latency", cyc - last_hs, 3);
    last_hs = cyc;
    for (int i = 0; i < req_st; i++) begin
      ifu_req_ready = 1'b0;
      @(negedge clk);
      check("req_hold_valid", {31'b0, ifu_req_valid}, 32'h1);
      check("req_hold_addr", ifu_req_addr, a);
    end
    ifu_req_ready = 1'b1;
    @(negedge clk);
    ifu_req_ready = 1'b0;
    check("rsp_ready", {31'b0, ifu_rsp_ready}, 32'h1);
    check("req_valid_off", {31'b0, ifu_req_valid}, 32'h0);
    for (int i = 0; i < rsp_st; i++) begin
      @(negedge clk);
      check("rsp_wait_ready", {31'b0, ifu_rsp_ready}, 32'h1);
      check("rsp_wait_start", {31'b0, exu_start}, 32'h0);
    end
    ifu_rsp_inst  = word;
    ifu_rsp_valid = 1'b1;
    inst_q.push_back(word);
    @(negedge clk);
    ifu_rsp_valid = 1'b0;
    ifu_rsp_inst  = 32'hdead_beef;
    w = (inst_q.size() > 0) ? inst_q.pop_front() : 32'hxxxx_xxxx;
    check("exu_start", {31'b0, exu_start}, 32'h1);
    check("inst", inst, w);
    check("exec_pc", pc, a);
    for (int i = 0; i < exu_st; i++) begin
      halt = (i == 0);
      @(negedge clk);
      halt = 1'b0;
      check("exec_stall_start", {31'b0, exu_start}, 32'h0);
      check("exec_stall_inst", inst, w);
      check("exec_stall_pc", pc, a);
      check("exec_stall_halted", {31'b0, halted}, 32'h0);
    end
    exu_done      = 1'b1;
    branch_taken  = taken;
    branch_target = tgt;
    halt          = hlt;
    if (hlt) begin
      nxt = a;
      exp_retire++;
    end else if (taken) begin
`ifdef NPC_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) begin
        trap = 1'b1;
        nxt  = a;
      end else begin
        nxt = tgt;
        exp_retire++;
      end
`else
      nxt = {tgt[31:2], 2'b00};
      exp_retire++;
`endif
    end else begin
      nxt = a + 32'd4;
      exp_retire++;
    end
    if (!hlt && !trap) addr_q.push_back(nxt);
    @(negedge clk);
    exu_done     = 1'b0;
    branch_taken = 1'b0;
    halt         = 1'b0;
    check("retire_cnt", retire_cnt, exp_retire);
    check("next_pc", pc, nxt);
    check("halted", {31'b0, halted}, {31'b0, (hlt | trap)});
    check("trap", {31'b0, misalign_trap}, {31'b0, trap});
    check("post_req_valid", {31'b0, ifu_req_valid}, {31'b0, !(hlt | trap)});
    check("post_exu_start", {31'b0, exu_start}, 32'h0);
    last_ok = (req_st == 0) && (rsp_st == 0) && (exu_st == 0);
  endtask

  initial begin
    logic [31:0] a;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_inst  = 32'h0;
    exu_done      = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    halt          = 1'b0;
    last_hs       = 0;
    last_ok       = 1'b0;
    exp_retire    = 32'h0;
    #2;
    apply_reset();

    // Back-to-back sequential instructions at minimum latency
    run_instr(32'h0000_0013, 1'b0, 32'h0, 1'b0, 0, 0, 0);
    run_instr(32'h0010_0093, 1'b0, 32'h0, 1'b0, 0, 0, 0);
    run_instr(32'h0020_0113, 1'b0, 32'h0, 1'b0, 0, 0, 0);
    // Request stalled five cycles
    run_instr(32'h0030_0193, 1'b0, 32'h0, 1'b0, 5, 0, 0);
    // Taken branch with response and EXU stalls plus a stray halt
    run_instr(32'h0f00_006f, 1'b1, 32'h8000_0100, 1'b0, 0, 2, 3);
    // Not-taken falls through to pc+4
    run_instr(32'h0000_0463, 1'b0, 32'h8000_0200, 1'b0, 0, 0, 0);

    // Reset asserted while waiting for the IMEM response
    wait_fetch(a);
    ifu_req_ready = 1'b1;
    @(negedge clk);
    ifu_req_ready = 1'b0;
    check("mid_rsp_ready", {31'b0, ifu_rsp_ready}, 32'h1);
    apply_reset();

    // Refetch from the reset vector, then ebreak
    run_instr(32'h0010_0073, 1'b0, 32'h0, 1'b1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      ifu_req_ready = 1'b1;
      ifu_rsp_valid = 1'b1;
      @(negedge clk);
      check("halt_no_req", {31'b0, ifu_req_valid}, 32'h0);
      check("halt_no_rsp", {31'b0, ifu_rsp_ready}, 32'h0);
      check("halt_stay", {31'b0, halted}, 32'h1);
      check("halt_pc", pc, RESET_PC);
    end
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;

    apply_reset();
    run_instr(32'h0000_0013, 1'b0, 32'h0, 1'b0, 0, 0, 0);
    // Misaligned taken target
    run_instr(32'h0000_0063, 1'b1, 32'h8000_0102, 1'b0, 0, 0, 0);
`ifndef NPC_MISALIGN_TRAP_EN
    run_instr(32'h0000_0013, 1'b0, 32'h0, 1'b0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
